// File: rtl/tri_bus_receiver_pkg.sv
// Shared definitions for the tristate bus receiver and its future transmitter peer.
// Handshake FSM state encodings and default bus/FIFO sizing.
package tri_bus_receiver_pkg;

   localparam int unsigned DATA_W_DEF = 16;
   localparam int unsigned DEPTH_DEF  = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACK  = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

endpackage

// File: rtl/tri_bus_receiver_sync_fifo.sv
// Show-ahead synchronous FIFO; head word is visible on rd_data, forced to zero while empty.
// Memory is not reset, so only pointers and the occupancy count carry reset state.
module sync_fifo #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [ADDR_W:0]   r_count;
   logic              w_push;
   logic              w_pop;
   logic              w_empty;
   logic              w_full;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == (ADDR_W+1)'(DEPTH));
   assign w_push  = wr_en & ~w_full;
   assign w_pop   = rd_en & ~w_empty;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= wr_data;
   end

   // Simultaneous push and pop leave the occupancy unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
            2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
   assign empty   = w_empty;
   assign full    = w_full;
   assign count   = r_count;

endmodule

// File: rtl/tri_bus_receiver.sv
// Receiver for the shared tristate bus: synchronises the transmitter strobe, runs the
// 4-phase strobe/ack handshake, queues captured words and flags a stuck handshake.
module tri_bus_receiver
   import tri_bus_receiver_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned DEPTH   = DEPTH_DEF,
   parameter int unsigned ADDR_W  = $clog2(DEPTH),
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] bus_data,
   input  logic              bus_strobe,
   output logic              bus_ack,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              timeout_err,
   input  logic              err_clr
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   logic             r_sync1;
   logic             r_strb_s;
   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_ack;
   logic             w_ack_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic             w_wr_en;
   logic             w_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1  <= 1'b0;
         r_strb_s <= 1'b0;
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_ack    <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_sync1  <= bus_strobe;
         r_strb_s <= r_sync1;
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_ack    <= w_ack_nxt;
         r_err    <= w_err_nxt;
      end
   end

   // Handshake: capture on synced strobe, ack until it drops, bail to ERR on timeout.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ack_nxt   = r_ack;
      w_err_nxt   = r_err;
      w_wr_en     = 1'b0;
      if (err_clr) w_err_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_ack_nxt = 1'b0;
            if (r_strb_s && !w_full) begin
               w_wr_en     = 1'b1;
               w_ack_nxt   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!r_strb_s) begin
               w_ack_nxt   = 1'b0;
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
               w_err_nxt   = 1'b1;
               w_ack_nxt   = 1'b0;
               w_state_nxt = ST_ERR;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         ST_ERR: begin
            w_ack_nxt = 1'b0;
            if (!r_strb_s) w_state_nxt = ST_IDLE;
         end
         default: begin
            w_ack_nxt   = 1'b0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (w_wr_en),
      .wr_data (bus_data),
      .rd_en   (rd_en),
      .rd_data (rd_data),
      .empty   (empty),
      .full    (w_full),
      .count   (count)
   );

   assign full        = w_full;
   assign bus_ack     = r_ack;
   assign timeout_err = r_err;

endmodule

// File: tb/tb_tri_bus_receiver.sv
// Self-checking bench for tri_bus_receiver: directed handshake scenarios plus a random
// send/pop mix, all compared against a queue-based model of the FIFO contents.
module tb_tri_bus_receiver;

   localparam int unsigned DW = 16;
   localparam int unsigned DP = 4;
   localparam int unsigned AW = 2;
   localparam int unsigned TO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] bus_data = '0;
   logic          bus_strobe = 1'b0;
   logic          bus_ack;
   logic          rd_en = 1'b0;
   logic [DW-1:0] rd_data;
   logic          empty;
   logic          full;
   logic [AW:0]   count;
   logic          timeout_err;
   logic          err_clr = 1'b0;

   int            n_checks = 0;
   int            n_errors = 0;
   logic [DW-1:0] q[$];

   tri_bus_receiver #(
      .DATA_W  (DW),
      .DEPTH   (DP),
      .ADDR_W  (AW),
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus_data    (bus_data),
      .bus_strobe  (bus_strobe),
      .bus_ack     (bus_ack),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [DW-1:0] head;
      head = (q.size() > 0) ? q[0] : '0;
      check({tag, "_count"}, 32'(count), 32'(q.size()));
      check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
      check({tag, "_full"},  32'(full),  32'(q.size() == DP));
      check({tag, "_head"},  32'(rd_data), 32'(head));
   endtask

   task automatic wait_ack(input logic v, input string tag);
      for (int i = 0; i < 20 && bus_ack !== v; i++) step();
      check(tag, 32'(bus_ack), 32'(v));
   endtask

   task automatic send(input logic [DW-1:0] w);
      bus_data   = w;
      bus_strobe = 1'b1;
      wait_ack(1'b1, "ack_rise");
      q.push_back(w);
      bus_strobe = 1'b0;
      wait_ack(1'b0, "ack_fall");
   endtask

   task automatic pop_check();
      check("pop_head", 32'(rd_data), 32'(q[0]));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      void'(q.pop_front());
      check_model("pop");
   endtask

   initial begin
      // Reset state
      step();
      check("rst_ack", 32'(bus_ack), 32'd0);
      check("rst_err", 32'(timeout_err), 32'd0);
      check_model("rst");
      step();
      rst_n = 1'b1;
      step();

      // Pop on empty
      rd_en = 1'b1;
      repeat (5) step();
      rd_en = 1'b0;
      check_model("pop_empty");
      check("pop_empty_ack", 32'(bus_ack), 32'd0);

      // Single word with exact latency
      bus_data   = 16'hA5C3;
      bus_strobe = 1'b1;
      step();
      check("lat_e1", 32'(bus_ack), 32'd0);
      step();
      check("lat_e2", 32'(bus_ack), 32'd0);
      step();
      check("lat_e3", 32'(bus_ack), 32'd1);
      q.push_back(16'hA5C3);
      check_model("single");
      bus_strobe = 1'b0;
      step();
      check("fall_e1", 32'(bus_ack), 32'd1);
      step();
      step();
      check("fall_e3", 32'(bus_ack), 32'd0);
      pop_check();

      // Fill and backpressure
      for (int i = 1; i <= 4; i++) send(DW'(i));
      check_model("fill");
      bus_data   = 16'h0005;
      bus_strobe = 1'b1;
      repeat (10) step();
      check("bp_ack", 32'(bus_ack), 32'd0);
      check_model("bp");
      check("bp_pop_head", 32'(rd_data), 32'h0001);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      void'(q.pop_front());
      step();
      check("bp_release_ack", 32'(bus_ack), 32'd1);
      q.push_back(16'h0005);
      bus_strobe = 1'b0;
      wait_ack(1'b0, "bp_fall");
      check_model("bp_after");
      for (int i = 2; i <= 5; i++) begin
         check("drain", 32'(rd_data), 32'(i));
         pop_check();
      end

      // Simultaneous pop and capture at count=2, then wrap over ten words
      send(16'h00AA);
      send(16'h00BB);
      bus_data   = 16'h00CC;
      bus_strobe = 1'b1;
      step();
      step();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("sim_ack", 32'(bus_ack), 32'd1);
      void'(q.pop_front());
      q.push_back(16'h00CC);
      check_model("sim");
      bus_strobe = 1'b0;
      wait_ack(1'b0, "sim_fall");
      while (q.size() > 0) pop_check();
      for (int i = 0; i < 10; i++) begin
         send(16'h0100 + DW'(i));
         if (q.size() >= 2) pop_check();
      end
      while (q.size() > 0) pop_check();

      // Timeout with a stuck strobe
      bus_data   = 16'h7E57;
      bus_strobe = 1'b1;
      wait_ack(1'b1, "to_ack");
      q.push_back(16'h7E57);
      for (int i = 0; i < 40 && timeout_err !== 1'b1; i++) step();
      check("to_err", 32'(timeout_err), 32'd1);
      check("to_ack_low", 32'(bus_ack), 32'd0);
      repeat (10) step();
      check_model("to_hold");
      check("to_hold_ack", 32'(bus_ack), 32'd0);
      bus_strobe = 1'b0;
      repeat (4) step();
      check("to_sticky", 32'(timeout_err), 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check("to_clr", 32'(timeout_err), 32'd0);
      send(16'h1234);
      check_model("to_recover");
      while (q.size() > 0) pop_check();

      // Random send/pop mix
      repeat (40) begin
         if (q.size() < DP && (q.size() == 0 || $urandom_range(0, 1) == 1))
            send(DW'($urandom));
         else
            pop_check();
         repeat ($urandom_range(0, 2)) step();
         check_model("rand");
      end

      // Asynchronous reset mid-handshake
      while (q.size() > 3) pop_check();
      while (q.size() < 3) send(DW'($urandom));
      bus_data   = 16'hBEEF;
      bus_strobe = 1'b1;
      wait_ack(1'b1, "rst_hs_ack");
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      check("rst_hs_ack_low", 32'(bus_ack), 32'd0);
      check_model("rst_hs");
      bus_strobe = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      check_model("rst_hs_after");
      send(16'h4242);
      pop_check();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
